ysyx_23060025_icache_axi_rd: RTL and testbench



---
 rtl/ysyx_23060025_icache_axi_rd.sv | 187 ++++++++++++++++++
 tb/tb_ysyx_23060025_icache_axi_rd.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_icache_axi_rd.sv
// Icache refill bridge: turns one refill request into exactly one AXI4 INCR read burst
// and returns each beat as a registered pulse. Optional checks: ICACHE_AXI_BEAT_CHECK_EN.
module ysyx_23060025_icache_axi_rd #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          ID_W       = 4,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] c_paddr,
    input  logic                  c_psel,
    input  logic [7:0]            c_arlen,
    input  logic [2:0]            c_arsize,
    output logic                  c_rvalid,
    output logic                  c_rlast,
    output logic [DATA_WIDTH-1:0] c_rdata,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    output logic [7:0]            axi_arlen,
    output logic [2:0]            axi_arsize,
    output logic [1:0]            axi_arburst,
    output logic [ID_W-1:0]       axi_arid,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rlast,
    input  logic [ID_W-1:0]       axi_rid,
    output logic                  err,
    output logic [1:0]            dbg_state_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Handshakes: a transfer happens on a rising clock edge where valid && ready; once
    // raised, valid and its payload hold until that edge. Every output here is a register.
    logic [1:0]            state_q, state_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [2:0]            arsize_q, arsize_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  c_rvalid_q, c_rvalid_d;
    logic                  c_rlast_q, c_rlast_d;
    logic [DATA_WIDTH-1:0] c_rdata_q, c_rdata_d;
    logic                  err_q, err_d;
    logic                  beat;
    logic                  burst_done;

    assign beat = axi_rvalid && rready_q;

    always_comb begin
        state_d    = state_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arsize_d   = arsize_q;
        beat_cnt_d = beat_cnt_q;
        c_rvalid_d = 1'b0;
        c_rlast_d  = 1'b0;
        c_rdata_d  = c_rdata_q;
        err_d      = err_q;
        burst_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // With no request pending, stray R beats left over from an aborted burst are swallowed.
                if (c_psel) begin
                    araddr_d  = c_paddr;
                    arlen_d   = c_arlen;
                    arsize_d  = c_arsize;
                    arvalid_d = 1'b1;
                    rready_d  = 1'b0;
                    state_d   = ST_ADDR;
                end else begin
                    rready_d = 1'b1;
                end
            end
            ST_ADDR: begin
                if (axi_arready) begin
                    arvalid_d  = 1'b0;
                    rready_d   = 1'b1;
                    beat_cnt_d = 8'd0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                rready_d = 1'b1;
                if (beat) begin
                    c_rvalid_d = 1'b1;
                    c_rdata_d  = axi_rdata;
                    c_rlast_d  = axi_rlast;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    burst_done = axi_rlast;
                    if (axi_rresp != 2'b00) begin
                        err_d = 1'b1;
                    end
`ifdef ICACHE_AXI_BEAT_CHECK_EN
                    if (axi_rid != ID_W'(AXI_ID)) begin
                        err_d = 1'b1;
                    end
                    if (axi_rlast && (beat_cnt_q != arlen_q)) begin
                        err_d = 1'b1;
                    end
                    // Slave overran arlen: close the burst locally so the cache still sees a last beat.
                    if (!axi_rlast && (beat_cnt_q == arlen_q)) begin
                        err_d      = 1'b1;
                        c_rlast_d  = 1'b1;
                        burst_done = 1'b1;
                    end
`endif
                    if (burst_done) begin
                        rready_d = 1'b0;
                        state_d  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The select still high here belongs to the finished refill.
                rready_d = 1'b0;
                if (!c_psel) begin
                    rready_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

`ifndef ICACHE_AXI_BEAT_CHECK_EN
    logic unused_rid;
    assign unused_rid = ^axi_rid;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= 8'd0;
            arsize_q   <= 3'd0;
            beat_cnt_q <= 8'd0;
            c_rvalid_q <= 1'b0;
            c_rlast_q  <= 1'b0;
            c_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arsize_q   <= arsize_d;
            beat_cnt_q <= beat_cnt_d;
            c_rvalid_q <= c_rvalid_d;
            c_rlast_q  <= c_rlast_d;
            c_rdata_q  <= c_rdata_d;
            err_q      <= err_d;
        end
    end

    assign c_rvalid    = c_rvalid_q;
    assign c_rlast     = c_rlast_q;
    assign c_rdata     = c_rdata_q;
    assign axi_araddr  = araddr_q;
    assign axi_arvalid = arvalid_q;
    assign axi_arlen   = arlen_q;
    assign axi_arsize  = arsize_q;
    assign axi_arburst = 2'b01;
    assign axi_arid    = ID_W'(AXI_ID);
    assign axi_rready  = rready_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_23060025_icache_axi_rd.sv
// Bench for ysyx_23060025_icache_axi_rd: the bench plays icache and AXI slave and checks
// beats, AR issue and the sticky error flag against a transaction-level expectation.
module tb_ysyx_23060025_icache_axi_rd;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic          clock;
    logic          reset;
    logic [AW-1:0] c_paddr;
    logic          c_psel;
    logic [7:0]    c_arlen;
    logic [2:0]    c_arsize;
    logic          c_rvalid;
    logic          c_rlast;
    logic [DW-1:0] c_rdata;
    logic [AW-1:0] axi_araddr;
    logic          axi_arvalid;
    logic          axi_arready;
    logic [7:0]    axi_arlen;
    logic [2:0]    axi_arsize;
    logic [1:0]    axi_arburst;
    logic [IW-1:0] axi_arid;
    logic          axi_rvalid;
    logic          axi_rready;
    logic [DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;
    logic [IW-1:0] axi_rid;
    logic          err;
    logic [1:0]    dbg_state_o;

    ysyx_23060025_icache_axi_rd #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_W(IW), .AXI_ID(0)
    ) dut (
        .clock(clock), .reset(reset),
        .c_paddr(c_paddr), .c_psel(c_psel), .c_arlen(c_arlen), .c_arsize(c_arsize),
        .c_rvalid(c_rvalid), .c_rlast(c_rlast), .c_rdata(c_rdata),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arid(axi_arid), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rid(axi_rid), .err(err), .dbg_state_o(dbg_state_o)
    );

    // Clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Scoreboard state
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW:0]   exp_q[$];
    bit            hs_prev  = 1'b0;
    logic          exp_err  = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge and check the beat port and error flag.
    task automatic tick_check();
        logic [DW:0] b;
        @(negedge clock);
        if (hs_prev) begin
            b = exp_q.pop_front();
            check_eq("c_rvalid", 64'(c_rvalid), 64'd1);
            check_eq("c_rdata", 64'(c_rdata), 64'(b[DW-1:0]));
            check_eq("c_rlast", 64'(c_rlast), 64'(b[DW]));
        end else begin
            check_eq("c_rvalid_quiet", 64'(c_rvalid), 64'd0);
        end
        check_eq("err", 64'(err), 64'(exp_err));
    endtask

    // Driver: one refill as seen from both the icache and the AXI slave side.
    task automatic refill(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input int ar_delay, input logic [15:0] pat, input int pat_len,
                          input bit rand_gap, input bit seq_data, input int err_beat,
                          input int early_last, input int hold, input int abort_after);
        bit          ar_seen    = 1'b0;
        bit          ar_hs      = 1'b0;
        int          ar_wait    = 0;
        int          ar_cnt     = 0;
        int          beats_sent = 0;
        int          slot       = 0;
        int          cyc        = 0;
        int          nbeats     = (early_last >= 0) ? early_last + 1 : int'(len) + 1;
        bit          v;
        logic [DW-1:0] d;
        logic [1:0]  resp;
        c_paddr  = addr;
        c_arlen  = len;
        c_arsize = size;
        c_psel   = 1'b1;
        hs_prev  = 1'b0;
        forever begin
            tick_check();
            if (ar_hs) begin
                ar_seen = 1'b1;
                ar_cnt++;
                ar_hs = 1'b0;
            end
            if (abort_after > 0 && beats_sent >= abort_after && exp_q.size() == 0) begin
                axi_rvalid = 1'b0;
                axi_rlast  = 1'b0;
                hs_prev    = 1'b0;
                return;
            end
            if (beats_sent == nbeats && exp_q.size() == 0) break;
            cyc++;
            if (cyc > 400) begin
                check_eq("timeout", 64'd1, 64'd0);
                break;
            end
            if (!ar_seen) begin
                if (axi_arvalid) begin
                    check_eq("araddr", 64'(axi_araddr), 64'(addr));
                    check_eq("arlen", 64'(axi_arlen), 64'(len));
                    check_eq("arsize", 64'(axi_arsize), 64'(size));
                    check_eq("arburst", 64'(axi_arburst), 64'd1);
                    check_eq("arid", 64'(axi_arid), 64'd0);
                    axi_arready = (ar_wait >= ar_delay);
                    ar_hs = axi_arready;
                    ar_wait++;
                end else begin
                    axi_arready = 1'b0;
                end
            end else begin
                axi_arready = 1'b0;
                check_eq("ar_once", 64'(axi_arvalid), 64'd0);
            end
            if (ar_seen && beats_sent < nbeats) begin
                check_eq("rready", 64'(axi_rready), 64'd1);
                if (slot < pat_len) v = pat[slot];
                else if (rand_gap) v = ($urandom_range(0, 2) != 0);
                else v = 1'b1;
                slot++;
                d = seq_data ? DW'((beats_sent + 1) * 17) : DW'($urandom);
                resp = (beats_sent == err_beat) ? 2'b10 : 2'b00;
                axi_rvalid = v;
                axi_rdata  = d;
                axi_rresp  = resp;
                axi_rlast  = (beats_sent == nbeats - 1);
                axi_rid    = '0;
                hs_prev    = v && axi_rready;
                if (hs_prev) begin
                    exp_q.push_back({axi_rlast, d});
                    if (resp != 2'b00) exp_err = 1'b1;
`ifdef ICACHE_AXI_BEAT_CHECK_EN
                    if (early_last >= 0 && beats_sent == early_last) exp_err = 1'b1;
`endif
                    beats_sent++;
                end
            end else begin
                axi_rvalid = 1'b0;
                axi_rlast  = 1'b0;
                hs_prev    = 1'b0;
            end
        end
        axi_rvalid  = 1'b0;
        axi_rlast   = 1'b0;
        axi_rresp   = 2'b00;
        axi_arready = 1'b0;
        hs_prev     = 1'b0;
        check_eq("ar_count", 64'(ar_cnt), 64'd1);
        for (int h = 0; h < hold; h++) begin
            tick_check();
            check_eq("ar_hold", 64'(axi_arvalid), 64'd0);
            check_eq("drain_state", 64'(dbg_state_o), 64'(ST_DRAIN));
        end
        c_psel = 1'b0;
        for (int h = 0; h < 2; h++) begin
            tick_check();
            check_eq("ar_after", 64'(axi_arvalid), 64'd0);
        end
    endtask

    initial begin
        reset       = 1'b0;
        c_paddr     = '0;
        c_psel      = 1'b0;
        c_arlen     = 8'd0;
        c_arsize    = 3'd0;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rdata   = '0;
        axi_rresp   = 2'b00;
        axi_rlast   = 1'b0;
        axi_rid     = '0;

        tick_check();
        check_eq("rst_arvalid", 64'(axi_arvalid), 64'd0);
        check_eq("rst_rready", 64'(axi_rready), 64'd0);
        check_eq("rst_c_rlast", 64'(c_rlast), 64'd0);
        check_eq("rst_c_rdata", 64'(c_rdata), 64'd0);
        check_eq("rst_araddr", 64'(axi_araddr), 64'd0);
        check_eq("rst_arlen", 64'(axi_arlen), 64'd0);
        check_eq("rst_arsize", 64'(axi_arsize), 64'd0);
        check_eq("rst_arburst", 64'(axi_arburst), 64'd1);
        check_eq("rst_state", 64'(dbg_state_o), 64'(ST_IDLE));
        reset = 1'b1;
        tick_check();
        tick_check();

        // Directed refill, select held one cycle past the last beat
        refill(32'h3000_0040, 8'd3, 3'd2, 2, 16'h0, 0, 1'b0, 1'b1, -1, -1, 1, 0);
        // Gapped R channel: rvalid 1,0,0,1,1,0,1
        refill(32'h3000_0080, 8'd3, 3'd2, 0, 16'h0059, 7, 1'b0, 1'b1, -1, -1, 0, 0);
        // Error response on beat 2
        refill(32'h3000_00c0, 8'd3, 3'd2, 1, 16'h0, 0, 1'b0, 1'b0, 1, -1, 1, 0);

        for (int r = 0; r < 16; r++) begin
            refill($urandom, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)), 16'h0, 0, 1'b1, 1'b0,
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1,
                   -1, int'($urandom_range(0, 2)), 0);
        end

        // Asynchronous reset after the first beat of a burst
        refill(32'h8000_0100, 8'd3, 3'd2, 0, 16'h0, 0, 1'b0, 1'b1, -1, -1, 0, 1);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_c_rvalid", 64'(c_rvalid), 64'd0);
        check_eq("arst_c_rdata", 64'(c_rdata), 64'd0);
        check_eq("arst_c_rlast", 64'(c_rlast), 64'd0);
        check_eq("arst_err", 64'(err), 64'd0);
        check_eq("arst_arvalid", 64'(axi_arvalid), 64'd0);
        check_eq("arst_rready", 64'(axi_rready), 64'd0);
        check_eq("arst_araddr", 64'(axi_araddr), 64'd0);
        check_eq("arst_arlen", 64'(axi_arlen), 64'd0);
        check_eq("arst_state", 64'(dbg_state_o), 64'(ST_IDLE));
        exp_err = 1'b0;
        exp_q.delete();
        hs_prev = 1'b0;
        c_psel  = 1'b0;
        tick_check();
        tick_check();
        reset = 1'b1;

        // Stray beats after release are swallowed without reaching the cache
        axi_rvalid = 1'b1;
        axi_rdata  = 32'hdead_0000;
        axi_rlast  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick_check();
            check_eq("stray_rready", 64'(axi_rready), 64'd1);
            axi_rdata = DW'(i + 1);
            axi_rlast = (i == 2);
        end
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        tick_check();
        check_eq("stray_arvalid", 64'(axi_arvalid), 64'd0);

        refill(32'h3000_0200, 8'd1, 3'd2, 1, 16'h0, 0, 1'b1, 1'b0, -1, -1, 0, 0);

        // Early rlast on beat 2 of a 4-beat burst
        refill(32'h3000_0300, 8'd3, 3'd2, 1, 16'h0, 0, 1'b0, 1'b1, -1, 1, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
